// File: rtl/cfg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cfg_ctrl_pkg : FSM states, packet field positions and field helpers
// Rev 1.0
// ============================================================================
package cfg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int CFG_RW_BIT   = 27;
  localparam int CFG_ADDR_LSB = 24;
  localparam int CFG_DATA_W   = 24;

  function automatic logic pkt_is_write(input logic [CFG_RW_BIT:0] f_pkt);
    return f_pkt[CFG_RW_BIT];
  endfunction

  function automatic logic [2:0] pkt_addr(input logic [CFG_RW_BIT:0] f_pkt);
    return f_pkt[CFG_ADDR_LSB +: 3];
  endfunction

  function automatic logic [CFG_DATA_W-1:0] pkt_data(input logic [CFG_RW_BIT:0] f_pkt);
    return f_pkt[CFG_DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// cfg_access_arbiter_if : requester, register-file and response signals
// Rev 1.0
// ============================================================================
interface cfg_access_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] s0_packet;
  logic             s0_valid;
  logic             s0_ready;
  logic [WIDTH-1:0] s1_packet;
  logic             s1_valid;
  logic             s1_ready;
  logic [WIDTH-1:0] cfg_packet;
  logic             cfg_write_en;
  logic             cfg_read_en;
  logic [WIDTH-9:0] cfg_read_data;
  logic             cfg_valid;
  logic [WIDTH-1:0] rsp_packet;
  logic             rsp_src;
  logic             rsp_err;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             busy;

  modport slave (
    input  s0_packet, s0_valid, s1_packet, s1_valid, cfg_read_data, cfg_valid, rsp_ready,
    output s0_ready, s1_ready, cfg_packet, cfg_write_en, cfg_read_en,
           rsp_packet, rsp_src, rsp_err, rsp_valid, busy
  );

  modport master (
    output s0_packet, s0_valid, s1_packet, s1_valid, cfg_read_data, cfg_valid, rsp_ready,
    input  s0_ready, s1_ready, cfg_packet, cfg_write_en, cfg_read_en,
           rsp_packet, rsp_src, rsp_err, rsp_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : two-way round-robin grant, last winner remembered on i_update
// Rev 1.0
// ============================================================================
module rr_arbiter2 (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] i_req,
  input  wire logic       i_update,
  output logic      [1:0] o_gnt
);

  // Reset value 1 lets requester 0 win the first contest.
  logic r_last_grant;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last_grant ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (i_update && (|o_gnt)) begin
      r_last_grant <= o_gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/cfg_access_arbiter.sv
`default_nettype none
// ============================================================================
// cfg_access_arbiter : shares the config register file between two requesters
// Rev 1.0
// ============================================================================
module cfg_access_arbiter
  import cfg_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ACK_WRITES = 1,
  parameter int TIMEOUT    = 15
) (
  input  wire logic            clk,
  input  wire logic            rst,
  cfg_access_arbiter_if.slave  bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_pkt;
  logic             r_src;
  logic [3:0]       r_timer;
  logic [WIDTH-1:0] r_rsp_packet;
  logic             r_rsp_err;

  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic             w_grant;
  logic             w_write_en;
  logic             w_read_en;
  logic             w_rsp_valid;
  logic             w_is_write;
  logic             w_timeout;

  assign w_req      = {bus.s1_valid, bus.s0_valid};
  assign w_is_write = pkt_is_write(r_pkt[CFG_RW_BIT:0]);
  assign w_timeout  = (r_timer == 4'(TIMEOUT - 1));

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_update (w_grant),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Ready is masked by rst so no requester sees a grant while reset is held.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_write_en   = 1'b0;
    w_read_en    = 1'b0;
    w_rsp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if ((|w_req) && !rst) begin
          w_grant      = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (w_is_write) begin
          w_write_en   = 1'b1;
          w_next_state = (ACK_WRITES != 0) ? RESP : IDLE;
        end else begin
          w_read_en = 1'b1;
          if (bus.cfg_valid || w_timeout) begin
            w_next_state = RESP;
          end
        end
      end
      RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt        <= '0;
      r_src        <= 1'b0;
      r_timer      <= 4'd0;
      r_rsp_packet <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_pkt   <= w_gnt[1] ? bus.s1_packet : bus.s0_packet;
        r_src   <= w_gnt[1];
        r_timer <= 4'd0;
      end
      if (r_state == ISSUE) begin
        if (w_is_write) begin
          r_rsp_packet <= r_pkt;
          r_rsp_err    <= 1'b0;
        end else if (bus.cfg_valid) begin
          r_rsp_packet <= {r_pkt[WIDTH-1:CFG_ADDR_LSB], bus.cfg_read_data[CFG_DATA_W-1:0]};
          r_rsp_err    <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_packet <= {r_pkt[WIDTH-1:CFG_ADDR_LSB], {CFG_DATA_W{1'b1}}};
          r_rsp_err    <= 1'b1;
        end else begin
          r_timer <= r_timer + 4'd1;
        end
      end
    end
  end

  assign bus.s0_ready     = w_grant & ~w_gnt[1];
  assign bus.s1_ready     = w_grant &  w_gnt[1];
  assign bus.cfg_packet   = r_pkt;
  assign bus.cfg_write_en = w_write_en;
  assign bus.cfg_read_en  = w_read_en;
  assign bus.rsp_packet   = r_rsp_packet;
  assign bus.rsp_src      = r_src;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.rsp_valid    = w_rsp_valid;
  assign bus.busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cfg_access_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cfg_access_arbiter : scoreboard bench with a behavioural 8x24 register file
// Rev 1.0
// ============================================================================
module tb_cfg_access_arbiter;

  logic clk;
  logic rst;
  cfg_access_arbiter_if #(.WIDTH(32)) bus ();

  cfg_access_arbiter #(.WIDTH(32), .ACK_WRITES(1), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pkt;
    logic        src;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_pulses = 0;
  int   rd_cycles = 0;
  int   ready_bad = 0;
  int   last_rsp_cyc = 0;
  logic cfg_respond;

  logic [23:0]  mem [8];
  logic [71:0]  outs;

  assign outs = {bus.s0_ready, bus.s1_ready, bus.cfg_packet, bus.cfg_write_en, bus.cfg_read_en,
                 bus.rsp_packet, bus.rsp_src, bus.rsp_err, bus.rsp_valid, bus.busy};

  assign bus.cfg_read_data = mem[bus.cfg_packet[26:24]];
  assign bus.cfg_valid     = cfg_respond & bus.cfg_read_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 24'h0;
    end else if (bus.cfg_write_en) begin
      mem[bus.cfg_packet[26:24]] <= bus.cfg_packet[23:0];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: strobe counters, ready sanity, and scoreboard pop on every response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cfg_write_en) wr_pulses++;
      if (bus.cfg_read_en)  rd_cycles++;
      if (bus.s0_ready && bus.s1_ready) ready_bad++;
      if ((bus.s0_ready || bus.s1_ready) && bus.busy) ready_bad++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        last_rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {95'd0, 1'b1, bus.rsp_packet}, 128'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_packet", bus.rsp_packet, e.pkt);
          chk("rsp_src", bus.rsp_src, e.src);
          chk("rsp_err", bus.rsp_err, e.err);
        end
      end
    end
  end

  task automatic expect_rsp(input logic [31:0] pkt, input logic src, input logic err);
    rsp_t e;
    e.pkt = pkt; e.src = src; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int src, input logic [31:0] pkt);
    @(posedge clk); #1;
    if (src == 0) begin bus.s0_packet = pkt; bus.s0_valid = 1'b1; end
    else          begin bus.s1_packet = pkt; bus.s1_valid = 1'b1; end
  endtask

  task automatic wait_accept(input int src, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if ((src == 0) ? bus.s0_ready : bus.s1_ready) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    if (!got) chk("accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    if (src == 0) bus.s0_valid = 1'b0;
    else          bus.s1_valid = 1'b0;
  endtask

  task automatic send(input int src, input logic [31:0] pkt, output int acc);
    drive(src, pkt);
    wait_accept(src, acc);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 128'd0, 128'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("outputs_in_reset", outs, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("outputs_after_reset", outs, 128'd0);
  endtask

  initial begin
    int a0, a1, a2, base, good;
    rst = 1'b1;
    cfg_respond = 1'b1;
    bus.s0_packet = '0; bus.s0_valid = 1'b0;
    bus.s1_packet = '0; bus.s1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    apply_reset();

    // 1: s0 write, echoed
    expect_rsp(32'h0A00_1234, 1'b0, 1'b0);
    base = wr_pulses;
    send(0, 32'h0A00_1234, a0);
    wait_idle();
    chk("write_pulses", wr_pulses - base, 1);

    // 2: s1 reads back the written value; accept-to-response latency
    expect_rsp(32'h0200_1234, 1'b1, 1'b0);
    send(1, 32'h0200_0000, a1);
    wait_idle();
    chk("rsp_latency", last_rsp_cyc - a1, 2);

    // 3: two contests after reset: s0 wins first, s1 wins second
    apply_reset();
    expect_rsp(32'h0B00_00AA, 1'b0, 1'b0);
    expect_rsp(32'h0300_00AA, 1'b1, 1'b0);
    expect_rsp(32'h0300_00AA, 1'b0, 1'b0);
    fork
      begin send(0, 32'h0B00_00AA, a0); send(0, 32'h0300_0000, a2); end
      begin send(1, 32'h0300_0000, a1); end
    join
    wait_idle();
    chk("contest1_gap", a1 - a0, 3);
    chk("contest2_gap", a2 - a1, 3);

    // 4: back-pressure holds the response and blocks new grants
    bus.rsp_ready = 1'b0;
    expect_rsp(32'h0C00_5555, 1'b1, 1'b0);
    send(1, 32'h0C00_5555, a1);
    drive(0, 32'h0400_0000);
    good = 0;
    for (int n = 0; n < 20 && !bus.rsp_valid; n++) @(negedge clk);
    chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_packet == 32'h0C00_5555 && bus.rsp_src && !bus.rsp_err &&
          bus.busy && !bus.s0_ready && !bus.s1_ready) good++;
    end
    chk("hold_stable_cycles", good, 5);
    expect_rsp(32'h0400_5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_accept(0, a0);
    wait_idle();

    // 5: read timeout, then recovery
    cfg_respond = 1'b0;
    expect_rsp(32'h01FF_FFFF, 1'b0, 1'b1);
    base = rd_cycles;
    send(0, 32'h0100_0000, a0);
    wait_idle();
    chk("timeout_read_cycles", rd_cycles - base, 15);
    cfg_respond = 1'b1;
    expect_rsp(32'h0300_00AA, 1'b1, 1'b0);
    send(1, 32'h0300_0000, a1);
    wait_idle();

    // 6: reset while a write is in ISSUE
    base = wr_pulses;
    drive(1, 32'h0D00_7777);
    wait_accept(1, a1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", outs, 128'd0);
    chk("abort_no_write", wr_pulses - base, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle_outputs", outs, 128'd0);
    expect_rsp(32'h0500_0000, 1'b0, 1'b0);
    expect_rsp(32'h0700_0000, 1'b1, 1'b0);
    fork
      send(0, 32'h0500_0000, a0);
      send(1, 32'h0700_0000, a1);
    join
    wait_idle();
    chk("post_abort_gap", a1 - a0, 3);

    chk("ready_violations", ready_bad, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
